// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
// master = controlling logic, slave = the counter itself.
interface counter_updown_mod_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             ack;
    logic [WIDTH-1:0] state;
    logic             terminal;
    logic             event_pulse;
    logic             sticky;

    modport master (
        output enable, up, load, load_value, ack,
        input  state, terminal, event_pulse, sticky
    );

    modport slave (
        input  enable, up, load, load_value, ack,
        output state, terminal, event_pulse, sticky
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Purpose: up/down modulo counter with load, wrap/saturate mode, terminal, event and sticky flags.
// Latency: state/event/sticky update one clock after sampling; terminal is combinational.
// Backpressure: none; every enabled edge counts, load takes priority over enable.
module counter_updown_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clock,
    input  logic                 clear_n,
    counter_updown_mod_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_nxt;
    logic             event_q;
    logic             sticky_q;
    logic             hit;

    // hit marks an edge that reaches past a range end, whether it wraps or holds
    always_comb begin
        state_nxt = state_q;
        hit       = 1'b0;
        if (bus.load) begin
            state_nxt = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;
        end else if (bus.enable) begin
            if (bus.up) begin
                if (state_q == MAX_VAL) begin
                    hit       = 1'b1;
                    state_nxt = SATURATE ? MAX_VAL : '0;
                end else begin
                    state_nxt = state_q + WIDTH'(1);
                end
            end else begin
                if (state_q == '0) begin
                    hit       = 1'b1;
                    state_nxt = SATURATE ? '0 : MAX_VAL;
                end else begin
                    state_nxt = state_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= '0;
            event_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            event_q <= hit;
            // a new event outranks an acknowledge on the same edge
            if (hit) begin
                sticky_q <= 1'b1;
            end else if (bus.ack) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.event_pulse = event_q;
    assign bus.sticky      = sticky_q;
    assign bus.terminal    = bus.up ? (state_q == MAX_VAL) : (state_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Randomized and directed bench for counter_updown_mod: three instances (4-wrap, 10-wrap,
// 10-saturate) share one stimulus stream and are compared against an arithmetic model.
module tb_counter_updown_mod;

    localparam int MODS [3] = '{4, 10, 10};
    localparam int SATS [3] = '{0, 0, 1};

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] lv = 4'd0;
    logic       ack = 1'b0;
    logic       chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    int ms [3];
    int me [3];
    int mk [3];

    always #5 clock = ~clock;

    counter_updown_mod_if #(.WIDTH(2)) bus0 ();
    counter_updown_mod_if #(.WIDTH(4)) bus1 ();
    counter_updown_mod_if #(.WIDTH(4)) bus2 ();

    assign bus0.enable = en;  assign bus1.enable = en;  assign bus2.enable = en;
    assign bus0.up     = up;  assign bus1.up     = up;  assign bus2.up     = up;
    assign bus0.load   = ld;  assign bus1.load   = ld;  assign bus2.load   = ld;
    assign bus0.ack    = ack; assign bus1.ack    = ack; assign bus2.ack    = ack;
    assign bus0.load_value = lv[1:0];
    assign bus1.load_value = lv;
    assign bus2.load_value = lv;

    counter_updown_mod #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) u0 (
        .clock(clock), .clear_n(clear_n), .bus(bus0));
    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u1 (
        .clock(clock), .clear_n(clear_n), .bus(bus1));
    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u2 (
        .clock(clock), .clear_n(clear_n), .bus(bus2));

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0; me[i] = 0; mk[i] = 0;
        end
    endfunction

    // Next value from the rules: clamp on load, step or wrap/hold at the range ends.
    function automatic void model_step();
        for (int i = 0; i < 3; i++) begin
            int m   = MODS[i];
            int lvi = (i == 0) ? (int'(lv) % 4) : int'(lv);
            int e   = 0;
            if (!clear_n) begin
                ms[i] = 0; me[i] = 0; mk[i] = 0;
                continue;
            end
            if (ld) begin
                ms[i] = (lvi < m) ? lvi : m - 1;
            end else if (en) begin
                if (up) begin
                    if (ms[i] == m - 1) begin
                        e = 1;
                        if (SATS[i] == 0) ms[i] = 0;
                    end else ms[i] = ms[i] + 1;
                end else begin
                    if (ms[i] == 0) begin
                        e = 1;
                        if (SATS[i] == 0) ms[i] = m - 1;
                    end else ms[i] = ms[i] - 1;
                end
            end
            me[i] = e;
            if (e == 1) mk[i] = 1;
            else if (ack) mk[i] = 0;
        end
    endfunction

    function automatic int model_term(int i);
        return up ? int'(ms[i] == MODS[i] - 1) : int'(ms[i] == 0);
    endfunction

    // Every-cycle comparison on the falling edge, away from input changes.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("state0",  int'(bus0.state),       ms[0]);
            chk("state1",  int'(bus1.state),       ms[1]);
            chk("state2",  int'(bus2.state),       ms[2]);
            chk("event0",  int'(bus0.event_pulse), me[0]);
            chk("event1",  int'(bus1.event_pulse), me[1]);
            chk("event2",  int'(bus2.event_pulse), me[2]);
            chk("sticky0", int'(bus0.sticky),      mk[0]);
            chk("sticky1", int'(bus1.sticky),      mk[1]);
            chk("sticky2", int'(bus2.sticky),      mk[2]);
            chk("term0",   int'(bus0.terminal),    model_term(0));
            chk("term1",   int'(bus1.terminal),    model_term(1));
            chk("term2",   int'(bus2.terminal),    model_term(2));
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_s0 [6] = '{1, 2, 3, 0, 1, 2};
        model_clear();
        #3;
        chk("rst_state", int'(bus1.state), 0);
        chk("rst_event", int'(bus1.event_pulse), 0);
        chk("rst_sticky", int'(bus1.sticky), 0);
        #5;
        clear_n = 1'b1;
        chk_en  = 1'b1;

        // 2-bit modulo-4 count up, wraps after the fourth edge
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t1_state0", int'(bus0.state), exp_s0[k]);
            chk("t1_event0", int'(bus0.event_pulse), (k == 3) ? 1 : 0);
        end
        chk("t1_sticky0", int'(bus0.sticky), 1);
        chk("t1_state1", int'(bus1.state), 6);

        // down-count from reset: 0 -> 9 -> 8
        clear_n = 1'b0; model_clear(); #1;
        clear_n = 1'b1; up = 1'b0; #1;
        chk("t2_term1", int'(bus1.terminal), 1);
        tick();
        chk("t2_state1a", int'(bus1.state), 9);
        chk("t2_event1a", int'(bus1.event_pulse), 1);
        chk("t2_state2a", int'(bus2.state), 0);
        tick();
        chk("t2_state1b", int'(bus1.state), 8);
        chk("t2_event1b", int'(bus1.event_pulse), 0);
        chk("t2_event2b", int'(bus2.event_pulse), 1);

        // saturating instance held at the top with enable on
        ld = 1'b1; lv = 4'd9; en = 1'b0;
        tick();
        chk("t3_load_state2", int'(bus2.state), 9);
        chk("t3_load_event2", int'(bus2.event_pulse), 0);
        ld = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_state2", int'(bus2.state), 9);
            chk("t3_event2", int'(bus2.event_pulse), 1);
        end

        // load beats enable and clamps an out-of-range value
        ld = 1'b1; en = 1'b1; lv = 4'd12;
        tick();
        chk("t4_state1", int'(bus1.state), 9);
        chk("t4_event1", int'(bus1.event_pulse), 0);

        // asynchronous clear mid-cycle
        en = 1'b0; lv = 4'd7;
        tick();
        chk("t5_state1_pre", int'(bus1.state), 7);
        ld = 1'b0;
        clear_n = 1'b0; model_clear(); #1;
        chk("t5_state1", int'(bus1.state), 0);
        chk("t5_event1", int'(bus1.event_pulse), 0);
        chk("t5_sticky1", int'(bus1.sticky), 0);
        clear_n = 1'b1;

        // ack on a wrap edge loses to the new event, then clears
        ld = 1'b1; lv = 4'd9;
        tick();
        ld = 1'b0; en = 1'b1; up = 1'b1; ack = 1'b1;
        tick();
        chk("t6_state1", int'(bus1.state), 0);
        chk("t6_sticky1a", int'(bus1.sticky), 1);
        en = 1'b0;
        tick();
        chk("t6_sticky1b", int'(bus1.sticky), 0);
        chk("t6_event1", int'(bus1.event_pulse), 0);
        ack = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                clear_n = 1'b0; model_clear(); #1;
                clear_n = 1'b1;
            end
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1) == 1;
            ld  = ($urandom_range(0, 7) == 0);
            lv  = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 3) == 0);
            tick();
        end

        @(negedge clock);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
